// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: refresh > write > read. A grant is registered one edge after the ARBIT decision, held until the owner's *_end, and followed by at least one NOP cycle.
// Optional SDRAM_ARBIT_RR_EN alternates write/read when both request together; refresh keeps absolute priority.
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BA_W-1:0]   aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_dq_oe,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DQ_W-1:0]   sdram_dq_out,
  output logic              sdram_dq_oe
);

  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   aref_en_q, wr_en_q, rd_en_q;
  state_t burst_pick;
  logic [3:0] cmd;

`ifdef SDRAM_ARBIT_RR_EN
  logic last_wr_q;

  // Contention between write and read goes to whichever did not own the bus last.
  always_comb begin
    burst_pick = S_ARBIT;
    if (wr_req && rd_req) burst_pick = last_wr_q ? S_READ : S_WRITE;
    else if (wr_req)      burst_pick = S_WRITE;
    else if (rd_req)      burst_pick = S_READ;
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      last_wr_q <= 1'b0;
    end else if (state_q == S_ARBIT && state_d == S_WRITE) begin
      last_wr_q <= 1'b1;
    end else if (state_q == S_ARBIT && state_d == S_READ) begin
      last_wr_q <= 1'b0;
    end
  end
`else
  always_comb begin
    burst_pick = S_ARBIT;
    if (wr_req)      burst_pick = S_WRITE;
    else if (rd_req) burst_pick = S_READ;
  end
`endif

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state_q   <= S_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= (state_d == S_AREF);
      wr_en_q   <= (state_d == S_WRITE);
      rd_en_q   <= (state_d == S_READ);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (!init_end)     state_d = S_INIT;
        else if (aref_req) state_d = S_AREF;
        else               state_d = burst_pick;
      end
      S_AREF:  if (aref_end) state_d = S_ARBIT;
      S_WRITE: if (wr_end)   state_d = S_ARBIT;
      S_READ:  if (rd_end)   state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  // Pins are forced to NOP while reset is asserted, even though INIT normally passes init_cmd through.
  always_comb begin
    cmd          = CMD_NOP;
    sdram_ba     = '1;
    sdram_addr   = '1;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = '0;
    if (sdram_rst_n) begin
      case (state_q)
        S_INIT: begin
          cmd        = init_cmd;
          sdram_ba   = init_ba;
          sdram_addr = init_addr;
        end
        S_AREF: begin
          cmd        = aref_cmd;
          sdram_ba   = aref_ba;
          sdram_addr = aref_addr;
        end
        S_WRITE: begin
          cmd          = wr_cmd;
          sdram_ba     = wr_ba;
          sdram_addr   = wr_addr;
          sdram_dq_oe  = wr_dq_oe;
          sdram_dq_out = wr_data;
        end
        S_READ: begin
          cmd        = rd_cmd;
          sdram_ba   = rd_ba;
          sdram_addr = rd_addr;
        end
        default: ;
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;
  assign aref_en   = aref_en_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = rd_en_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit; expected grant order depends on SDRAM_ARBIT_RR_EN.
module tb_sdram_arbit;
  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;
`ifdef SDRAM_ARBIT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              sdram_clk = 1'b0;
  logic              sdram_rst_n = 1'b0;
  logic              init_end = 1'b0;
  logic [3:0]        init_cmd = 4'b0010;
  logic [BA_W-1:0]   init_ba = 2'b01;
  logic [ADDR_W-1:0] init_addr = 13'h0400;
  logic              aref_req = 1'b0, aref_end = 1'b0;
  logic [3:0]        aref_cmd = 4'b0001;
  logic [BA_W-1:0]   aref_ba = 2'b10;
  logic [ADDR_W-1:0] aref_addr = 13'h0011;
  logic              wr_req = 1'b0, wr_end = 1'b0;
  logic [3:0]        wr_cmd = 4'b0100;
  logic [BA_W-1:0]   wr_ba = 2'b00;
  logic [ADDR_W-1:0] wr_addr = 13'h0123;
  logic              wr_dq_oe = 1'b1;
  logic [DQ_W-1:0]   wr_data = 16'hA5A5;
  logic              rd_req = 1'b0, rd_end = 1'b0;
  logic [3:0]        rd_cmd = 4'b0101;
  logic [BA_W-1:0]   rd_ba = 2'b11;
  logic [ADDR_W-1:0] rd_addr = 13'h0456;

  logic aref_en, wr_en, rd_en, sdram_cke;
  logic sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DQ_W-1:0]   sdram_dq_out;
  logic              sdram_dq_oe;
  logic [3:0] pins;
  logic [2:0] en;

  int checks = 0;
  int errors = 0;

  assign pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
  assign en   = {aref_en, wr_en, rd_en};

  sdram_arbit #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
    .sdram_clk(sdram_clk), .sdram_rst_n(sdram_rst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
    .wr_dq_oe(wr_dq_oe), .wr_data(wr_data),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
  );

  always #5 sdram_clk = ~sdram_clk;

  task automatic test_reset();
    sdram_rst_n = 1'b0;
    init_end = 1'b0;
    #12;
    checks++; if (pins !== 4'b0111) begin errors++; $display("FAIL rst_pins got %b want 0111", pins); end
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL rst_en got %b want 000", en); end
    checks++; if (sdram_ba !== 2'b11 || sdram_addr !== 13'h1fff) begin errors++; $display("FAIL rst_ba_addr got %b/%h want 11/1fff", sdram_ba, sdram_addr); end
    checks++; if (sdram_dq_oe !== 1'b0 || sdram_dq_out !== 16'h0 || sdram_cke !== 1'b1) begin errors++; $display("FAIL rst_dq_cke got oe=%b dq=%h cke=%b want 0/0000/1", sdram_dq_oe, sdram_dq_out, sdram_cke); end
    @(negedge sdram_clk) sdram_rst_n = 1'b1;
    @(negedge sdram_clk);
    checks++; if (pins !== 4'b0010 || sdram_ba !== 2'b01 || sdram_addr !== 13'h0400) begin errors++; $display("FAIL init_pass got %b/%b/%h want 0010/01/0400", pins, sdram_ba, sdram_addr); end
    repeat (2) @(negedge sdram_clk);
    checks++; if (pins !== 4'b0010 || en !== 3'b000) begin errors++; $display("FAIL init_hold got %b en %b want 0010 en 000", pins, en); end
    init_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (pins !== 4'b0111 || en !== 3'b000) begin errors++; $display("FAIL arbit_entry got %b en %b want 0111 en 000", pins, en); end
  endtask

  task automatic test_write();
    wr_req = 1'b1;
    #1;
    checks++; if (pins !== 4'b0111 || en !== 3'b000) begin errors++; $display("FAIL wr_decide got %b en %b want 0111 en 000", pins, en); end
    @(negedge sdram_clk);
    checks++; if (en !== 3'b010) begin errors++; $display("FAIL wr_grant got %b want 010", en); end
    checks++; if (pins !== 4'b0100 || sdram_ba !== 2'b00 || sdram_addr !== 13'h0123) begin errors++; $display("FAIL wr_pins got %b/%b/%h want 0100/00/0123", pins, sdram_ba, sdram_addr); end
    checks++; if (sdram_dq_oe !== 1'b1 || sdram_dq_out !== 16'hA5A5) begin errors++; $display("FAIL wr_dq got %b/%h want 1/a5a5", sdram_dq_oe, sdram_dq_out); end
    wr_req = 1'b0;
    wr_dq_oe = 1'b0;
    #1;
    checks++; if (sdram_dq_oe !== 1'b0) begin errors++; $display("FAIL wr_dq_oe_follow got %b want 0", sdram_dq_oe); end
    rd_end = 1'b1; aref_end = 1'b1; init_end = 1'b0;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b010 || pins !== 4'b0100) begin errors++; $display("FAIL wr_ignore got en %b pins %b want 010/0100", en, pins); end
    rd_end = 1'b0; aref_end = 1'b0; init_end = 1'b1; wr_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000 || pins !== 4'b0111 || sdram_dq_oe !== 1'b0) begin errors++; $display("FAIL wr_release got en %b pins %b oe %b want 000/0111/0", en, pins, sdram_dq_oe); end
    wr_end = 1'b0; wr_dq_oe = 1'b1;
  endtask

  task automatic test_priority();
    logic [2:0] first_en, second_en;
    logic [3:0] first_cmd;
    first_en  = RR ? 3'b001 : 3'b010;
    second_en = RR ? 3'b010 : 3'b001;
    first_cmd = RR ? 4'b0101 : 4'b0100;
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b100 || pins !== 4'b0001 || sdram_ba !== 2'b10) begin errors++; $display("FAIL pri_aref got en %b pins %b ba %b want 100/0001/10", en, pins, sdram_ba); end
    aref_req = 1'b0; aref_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000 || pins !== 4'b0111) begin errors++; $display("FAIL pri_nop1 got en %b pins %b want 000/0111", en, pins); end
    aref_end = 1'b0;
    @(negedge sdram_clk);
    checks++; if (en !== first_en || pins !== first_cmd) begin errors++; $display("FAIL pri_second got en %b pins %b want %b/%b", en, pins, first_en, first_cmd); end
    if (RR) begin rd_req = 1'b0; rd_end = 1'b1; end else begin wr_req = 1'b0; wr_end = 1'b1; end
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000 || pins !== 4'b0111) begin errors++; $display("FAIL pri_nop2 got en %b pins %b want 000/0111", en, pins); end
    rd_end = 1'b0; wr_end = 1'b0;
    @(negedge sdram_clk);
    checks++; if (en !== second_en) begin errors++; $display("FAIL pri_third got en %b want %b", en, second_en); end
    wr_req = 1'b0; rd_req = 1'b0;
    if (RR) wr_end = 1'b1; else rd_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL pri_done got en %b want 000", en); end
    wr_end = 1'b0; rd_end = 1'b0;
  endtask

  task automatic test_aref_mid_write();
    wr_req = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b010) begin errors++; $display("FAIL mid_wr_grant got %b want 010", en); end
    wr_req = 1'b0; aref_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sdram_clk);
      checks++; if (en !== 3'b010) begin errors++; $display("FAIL mid_no_preempt cycle %0d got %b want 010", i, en); end
    end
    wr_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000 || pins !== 4'b0111) begin errors++; $display("FAIL mid_nop got en %b pins %b want 000/0111", en, pins); end
    wr_end = 1'b0;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b100 || pins !== 4'b0001) begin errors++; $display("FAIL mid_aref got en %b pins %b want 100/0001", en, pins); end
    aref_req = 1'b0; aref_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL mid_aref_done got %b want 000", en); end
    aref_end = 1'b0;
  endtask

  task automatic test_init_drop();
    init_end = 1'b0;
    @(negedge sdram_clk);
    checks++; if (pins !== 4'b0010 || en !== 3'b000) begin errors++; $display("FAIL drop_init got pins %b en %b want 0010/000", pins, en); end
    wr_req = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL drop_no_grant got %b want 000", en); end
    init_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (pins !== 4'b0111 || en !== 3'b000) begin errors++; $display("FAIL drop_rearbit got pins %b en %b want 0111/000", pins, en); end
    @(negedge sdram_clk);
    checks++; if (en !== 3'b010) begin errors++; $display("FAIL drop_wr_grant got %b want 010", en); end
    wr_req = 1'b0; wr_end = 1'b1;
    @(negedge sdram_clk);
    wr_end = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1;
    @(negedge sdram_clk);
    checks++; if (en !== 3'b001 || pins !== 4'b0101) begin errors++; $display("FAIL rm_rd_grant got en %b pins %b want 001/0101", en, pins); end
    rd_req = 1'b0;
    #2 sdram_rst_n = 1'b0;
    #1;
    checks++; if (en !== 3'b000 || pins !== 4'b0111 || sdram_ba !== 2'b11) begin errors++; $display("FAIL rm_async got en %b pins %b ba %b want 000/0111/11", en, pins, sdram_ba); end
    init_end = 1'b0;
    @(negedge sdram_clk) sdram_rst_n = 1'b1;
    @(negedge sdram_clk);
    checks++; if (pins !== 4'b0010 || en !== 3'b000) begin errors++; $display("FAIL rm_init got pins %b en %b want 0010/000", pins, en); end
    init_end = 1'b1;
    @(negedge sdram_clk);
    checks++; if (pins !== 4'b0111) begin errors++; $display("FAIL rm_arbit got pins %b want 0111", pins); end
  endtask

  task automatic test_back_to_back();
    int got, exp;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int c = 0; c < 6 && got == 0; c++) begin
        @(negedge sdram_clk);
        if (wr_en === 1'b1) got = 1;
        else if (rd_en === 1'b1) got = 2;
      end
      exp = (RR && (k % 2 == 1)) ? 2 : 1;
      checks++; if (got != exp) begin errors++; $display("FAIL b2b_order burst %0d got %0d want %0d (1=W 2=R 0=none)", k, got, exp); end
      if (got == 1) wr_end = 1'b1;
      else if (got == 2) rd_end = 1'b1;
      @(negedge sdram_clk);
      wr_end = 1'b0; rd_end = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge sdram_clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_priority();
    test_aref_mid_write();
    test_init_drop();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
